// File: rtl/master_slave_link_if.sv
// A/D channel bundle for the memory-access link. The master modport is the link itself
// (drives both channels' valid/payload), the slave modport is the environment supplying readies.
interface master_slave_link_if #(
    parameter int unsigned A_CHANNEL_SIZE = 53,
    parameter int unsigned D_CHANNEL_SIZE = 43
);
    logic                      a_valid;
    logic                      a_ready;
    logic [A_CHANNEL_SIZE-1:0] a_channel;
    logic                      d_valid;
    logic                      d_ready;
    logic [D_CHANNEL_SIZE-1:0] d_channel;
    logic                      d_error;
    logic                      backpressureslave;

    modport master (
        output a_valid,
        output a_channel,
        output d_valid,
        output d_channel,
        output d_error,
        output backpressureslave,
        input  a_ready,
        input  d_ready
    );

    modport slave (
        input  a_valid,
        input  a_channel,
        input  d_valid,
        input  d_channel,
        input  d_error,
        input  backpressureslave,
        output a_ready,
        output d_ready
    );
endinterface

// File: rtl/master_slave_link.sv
// Load/store request master plus word-addressed memory slave, joined by TileLink-style
// A/D channels with externally supplied readies. One request outstanding at a time.
module master_slave_link #(
    parameter int unsigned A_CHANNEL_SIZE = 53,
    parameter int unsigned D_CHANNEL_SIZE = 43,
    parameter int unsigned MEM_DEPTH      = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         ir34,
    input  logic [31:0]         z4_input,
    input  logic [31:0]         md4_input,
    master_slave_link_if.master bus,
    output logic [31:0]         load_data
);

    localparam int unsigned AddrW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [16:0] MemDepthW = 17'(MEM_DEPTH);

    localparam logic [6:0] StoreOp = 7'b0100011;
    localparam logic [6:0] LoadOp  = 7'b0000011;

    localparam logic [2:0] OpPutFull       = 3'd0;
    localparam logic [2:0] OpGet           = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;
    localparam logic [1:0] SizeWord        = 2'd2;

    typedef enum logic [1:0] {StIdle, StReq, StWaitD} state_e;

    // ---------------------------------------------------------------- master
    state_e                    state_q, state_d;
    logic [A_CHANNEL_SIZE-1:0] a_req_q, a_req_d;
    logic [31:0]               load_data_q, load_data_d;
    logic                      is_store, is_load;
    logic                      a_valid, a_fire;
    logic [A_CHANNEL_SIZE-1:0] a_channel;

    // ---------------------------------------------------------------- slave
    logic [31:0]               mem_q [MEM_DEPTH];
    logic                      d_valid_q;
    logic [D_CHANNEL_SIZE-1:0] d_rsp_q, d_rsp;
    logic                      d_fire;
    logic [2:0]                a_op;
    logic [15:0]               a_addr;
    logic [31:0]               a_data;
    logic [AddrW-1:0]          mem_idx;
    logic                      in_range;
    logic                      mem_we;
    logic [2:0]                rsp_op;
    logic                      rsp_denied;
    logic [31:0]               rsp_data;

    logic unused_bits;
    assign unused_bits = ^{ir34[31:7], z4_input[31:16], a_channel[49:48]};

    assign is_store = (ir34[6:0] == StoreOp);
    assign is_load  = (ir34[6:0] == LoadOp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            a_req_q     <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            a_req_q     <= a_req_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_req_d     = a_req_q;
        load_data_d = load_data_q;
        unique case (state_q)
            StIdle: begin
                if (is_store || is_load) begin
                    state_d = StReq;
                    a_req_d = {is_store ? OpPutFull : OpGet, SizeWord, z4_input[15:0],
                               is_store ? md4_input : 32'd0};
                end
            end
            StReq: begin
                if (bus.a_ready) begin
                    state_d = StWaitD;
                end
            end
            StWaitD: begin
                if (d_valid_q && bus.d_ready) begin
                    state_d = StIdle;
                    // Only successful reads update the architectural load result.
                    if (d_rsp_q[42:40] == OpAccessAckData && !d_rsp_q[33]) begin
                        load_data_d = d_rsp_q[31:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        a_valid   = (state_q == StReq);
        a_channel = a_valid ? a_req_q : '0;
    end

    assign a_fire        = a_valid && bus.a_ready;
    assign bus.a_valid   = a_valid;
    assign bus.a_channel = a_channel;
    assign load_data     = load_data_q;

    // ---------------------------------------------------------------- slave decode
    assign a_op     = a_channel[52:50];
    assign a_addr   = a_channel[47:32];
    assign a_data   = a_channel[31:0];
    assign mem_idx  = a_addr[AddrW-1:0];
    assign in_range = ({1'b0, a_addr} < MemDepthW);

    always_comb begin
        rsp_op     = OpAccessAck;
        rsp_denied = 1'b1;
        rsp_data   = '0;
        mem_we     = 1'b0;
        case (a_op)
            OpPutFull: begin
                rsp_op     = OpAccessAck;
                rsp_denied = !in_range;
                mem_we     = a_fire && in_range;
            end
            OpGet: begin
                rsp_op     = OpAccessAckData;
                rsp_denied = !in_range;
                rsp_data   = in_range ? mem_q[mem_idx] : 32'd0;
            end
            default: ;
        endcase
    end

    assign d_rsp = {rsp_op, SizeWord, 4'd0, rsp_denied, 1'b0, rsp_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= a_data;
        end
    end

    // A and D transfers never coincide: the master waits for D before the next A.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid_q <= 1'b0;
            d_rsp_q   <= '0;
        end else if (a_fire) begin
            d_valid_q <= 1'b1;
            d_rsp_q   <= d_rsp;
        end else if (d_fire) begin
            d_valid_q <= 1'b0;
            d_rsp_q   <= '0;
        end
    end

    assign d_fire                = d_valid_q && bus.d_ready;
    assign bus.d_valid           = d_valid_q;
    assign bus.d_channel         = d_valid_q ? d_rsp_q : '0;
    assign bus.d_error           = d_valid_q && d_rsp_q[33];
    assign bus.backpressureslave = d_valid_q && !bus.d_ready;

endmodule

// File: tb/tb_master_slave_link.sv
// Scoreboard bench for master_slave_link: expected D responses are queued when a request
// is driven and compared when the response handshakes.
module tb_master_slave_link;

    localparam logic [31:0] IrStore = 32'h23;
    localparam logic [31:0] IrLoad  = 32'h03;

    logic        clk;
    logic        reset;
    logic [31:0] ir34;
    logic [31:0] z4_input;
    logic [31:0] md4_input;
    logic [31:0] load_data;

    master_slave_link_if #(.A_CHANNEL_SIZE(53), .D_CHANNEL_SIZE(43)) bus ();

    master_slave_link #(
        .A_CHANNEL_SIZE(53),
        .D_CHANNEL_SIZE(43),
        .MEM_DEPTH     (256)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ir34     (ir34),
        .z4_input (z4_input),
        .md4_input(md4_input),
        .bus      (bus),
        .load_data(load_data)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [42:0] exp_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] exp_load;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (reset && bus.d_valid && bus.d_ready) begin
            check_eq("rsp_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                logic [42:0] e;
                e = exp_q.pop_front();
                check_eq("d_channel", 64'(bus.d_channel), 64'(e));
                check_eq("d_error", 64'(bus.d_error), 64'(e[33]));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        exp_load = '0;
    endtask

    task automatic do_req(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] data,
                          input int a_stall, input int d_stall);
        logic [52:0] exp_a;
        logic [42:0] exp_d;
        logic        in_rng;
        logic        st;
        bit          seen;
        st     = (ir == IrStore);
        in_rng = (addr[15:0] < 16'd256);
        if (st) begin
            exp_a = {3'd0, 2'd2, addr[15:0], data};
            exp_d = {3'd0, 2'd2, 4'd0, !in_rng, 1'b0, 32'd0};
            if (in_rng) model_mem[addr[7:0]] = data;
        end else begin
            exp_a = {3'd4, 2'd2, addr[15:0], 32'd0};
            exp_d = {3'd1, 2'd2, 4'd0, !in_rng, 1'b0, in_rng ? model_mem[addr[7:0]] : 32'd0};
            if (in_rng) exp_load = model_mem[addr[7:0]];
        end
        exp_q.push_back(exp_d);

        @(posedge clk); #2;
        ir34      = ir;
        z4_input  = addr;
        md4_input = data;
        bus.a_ready = (a_stall == 0);
        bus.d_ready = (d_stall == 0);
        @(posedge clk); #2;
        ir34 = '0;
        check_eq("a_valid", 64'(bus.a_valid), 64'd1);
        check_eq("a_channel", 64'(bus.a_channel), 64'(exp_a));
        for (int i = 0; i < a_stall; i++) begin
            @(posedge clk); #2;
            check_eq("a_stall_valid", 64'(bus.a_valid), 64'd1);
            check_eq("a_stall_chan", 64'(bus.a_channel), 64'(exp_a));
            check_eq("a_stall_dvalid", 64'(bus.d_valid), 64'd0);
        end
        bus.a_ready = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #2;
            seen = bus.d_valid;
        end
        check_eq("d_valid_rise", 64'(seen), 64'd1);
        check_eq("a_valid_drop", 64'(bus.a_valid), 64'd0);
        for (int i = 0; i < d_stall; i++) begin
            check_eq("d_stall_valid", 64'(bus.d_valid), 64'd1);
            check_eq("d_stall_bp", 64'(bus.backpressureslave), 64'd1);
            check_eq("d_stall_chan", 64'(bus.d_channel), 64'(exp_d));
            @(posedge clk); #2;
        end
        bus.d_ready = 1'b1;
        @(posedge clk); #2;
        check_eq("d_valid_clear", 64'(bus.d_valid), 64'd0);
        check_eq("d_channel_clear", 64'(bus.d_channel), 64'd0);
        check_eq("bp_clear", 64'(bus.backpressureslave), 64'd0);
        check_eq("load_data", 64'(load_data), 64'(exp_load));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        ir34        = '0;
        z4_input    = '0;
        md4_input   = '0;
        bus.a_ready = 1'b1;
        bus.d_ready = 1'b1;
        model_reset();
        #1;
        check_eq("rst_a_valid", 64'(bus.a_valid), 64'd0);
        check_eq("rst_a_channel", 64'(bus.a_channel), 64'd0);
        check_eq("rst_d_valid", 64'(bus.d_valid), 64'd0);
        check_eq("rst_d_error", 64'(bus.d_error), 64'd0);
        check_eq("rst_load_data", 64'(load_data), 64'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;

        // Store then load, then overwrite.
        do_req(IrStore, 32'd10, 32'd20, 0, 0);
        do_req(IrLoad,  32'd10, 32'd0,  0, 0);
        do_req(IrStore, 32'd10, 32'd30, 0, 0);
        do_req(IrLoad,  32'd10, 32'd0,  0, 0);

        // Back-pressure on D, then on A.
        do_req(IrLoad,  32'd10, 32'd0,        0, 3);
        do_req(IrStore, 32'd5,  32'h5555_aaaa, 2, 0);
        do_req(IrLoad,  32'd5,  32'd0,        0, 0);

        // Out of range: denied, no aliasing into address 300 % 256.
        do_req(IrStore, 32'd300, 32'd99, 0, 0);
        do_req(IrLoad,  32'd300, 32'd0,  0, 0);
        do_req(IrLoad,  32'd44,  32'd0,  0, 0);

        // Non-memory opcode issues nothing.
        @(posedge clk); #2;
        ir34 = 32'h13;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check_eq("ignore_a_valid", 64'(bus.a_valid), 64'd0);
        end
        ir34 = '0;

        for (int n = 0; n < 10; n++) begin
            do_req(($urandom_range(0, 1) == 1) ? IrStore : IrLoad, $urandom_range(0, 300),
                   $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // Reset while a store is stuck in REQ.
        @(posedge clk); #2;
        ir34        = IrStore;
        z4_input    = 32'd10;
        md4_input   = 32'd77;
        bus.a_ready = 1'b0;
        @(posedge clk); #2;
        ir34 = '0;
        check_eq("pre_rst_a_valid", 64'(bus.a_valid), 64'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_a_valid", 64'(bus.a_valid), 64'd0);
        check_eq("mid_rst_a_channel", 64'(bus.a_channel), 64'd0);
        check_eq("mid_rst_d_valid", 64'(bus.d_valid), 64'd0);
        check_eq("mid_rst_bp", 64'(bus.backpressureslave), 64'd0);
        check_eq("mid_rst_load_data", 64'(load_data), 64'd0);
        model_reset();
        @(posedge clk); #2;
        reset       = 1'b1;
        bus.a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check_eq("post_rst_idle", 64'(bus.a_valid), 64'd0);
        end
        do_req(IrLoad, 32'd10, 32'd0, 0, 0);

        @(posedge clk); #2;
        check_eq("rsp_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/master_slave_link.md
# master_slave_link

Single-clock memory-access link: a request master turns RISC-V load/store instructions into TileLink-style A-channel requests, and a memory slave executes them and returns D-channel responses. It sits between the pipeline's memory stage (instruction `ir34`, address `z4_input`, store data `md4_input`) and a local data memory. Ready on both channels comes from outside so that back-pressure can be injected. One request may be outstanding at a time.

## Interface
- `A_CHANNEL_SIZE`, 53: A-channel width, fixed field layout.
- `D_CHANNEL_SIZE`, 43: D-channel width, fixed field layout.
- `MEM_DEPTH`, 256: slave memory size in 32-bit words (power of two, ≤ 65536).
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `ir34` in 32: instruction; only `ir34[6:0]` is decoded.
- `z4_input` in 32: request address (word index).
- `md4_input` in 32: store data.
- `a_ready` in 1: A-channel ready, seen by both master and slave.
- `d_ready` in 1: D-channel ready, seen by both master and slave.
- `a_valid` out 1: A-channel valid.
- `a_channel` out 53: bits [52:50] opcode (0 = PutFullData, 4 = Get); [49:48] size, always 2; [47:32] address = `z4_input[15:0]`; [31:0] data (store data, 0 for Get).
- `d_valid` out 1: D-channel valid.
- `d_channel` out 43: bits [42:40] opcode (0 = AccessAck, 1 = AccessAckData); [39:38] size = 2; [37:34] 0; [33] denied; [32] corrupt = 0; [31:0] read data (0 for AccessAck or on error).
- `d_error` out 1: equals `d_channel[33]` while `d_valid`, otherwise 0.
- `backpressureslave` out 1: slave holds a response that has not been accepted (`d_valid && !d_ready`).
- `load_data` out 32: data from the last successful AccessAckData.

## Operation
- Instruction decode:
  - `ir34[6:0]` = 7'b0100011 is a store, issued as PutFullData.
  - 7'b0000011 is a load, issued as Get.
  - Any other value is ignored.
- Master FSM:
  - IDLE: if a load or store is decoded, register `a_channel` from the inputs, set `a_valid`=1, go to REQ.
  - REQ: hold `a_valid` and `a_channel` stable. When `a_ready`=1 the transfer occurs; clear `a_valid`, go to WAIT_D.
  - WAIT_D: when `d_valid && d_ready`, go to IDLE. If the opcode is AccessAckData and denied=0, load `d_channel[31:0]` into `load_data`.
  - An instruction held across cycles is reissued after each completed response.
  - `a_channel` reads 0 whenever `a_valid`=0.
- Slave:
  - On an A transfer (`a_valid && a_ready`), decode the address. The request is in range if `addr[15:0] < MEM_DEPTH`.
  - In-range Put: write the data to memory; respond AccessAck, data 0.
  - In-range Get: respond AccessAckData with `mem[addr]`.
  - Out-of-range Put: no memory write; respond AccessAck with denied=1.
  - Out-of-range Get: respond AccessAckData with denied=1, data 0.
  - Unknown A opcode: AccessAck with denied=1.
  - The response is held until `d_valid && d_ready`; then `d_valid` and `d_channel` clear to 0.
  - `d_channel` reads 0 whenever `d_valid`=0.
- Memory is word-addressed and synchronous-write; reset clears it to zero.

## Timing
- Reset (async, `reset`=0) values:
  - `a_valid`=0, `a_channel`=0.
  - `d_valid`=0, `d_channel`=0, `d_error`=0.
  - `backpressureslave`=0, `load_data`=0.
  - Master FSM = IDLE; memory all zero.
- Asserting reset mid-transaction abandons it; no partial write occurs unless the write edge already happened.
- Request: decode at edge N, then `a_valid`=1 after edge N.
- A transfer at the first edge M ≥ N+1 where `a_ready`=1. At the same edge M:
  - memory is written (for a Put);
  - `d_valid` rises.
- The response completes at the first edge ≥ M+1 where `d_ready`=1.
  - The master returns to IDLE at that edge.
  - It can issue the next `a_valid` after the following edge.
- Minimum store-to-store spacing is 3 cycles with both readies held at 1.
- `backpressureslave` is combinational: `d_valid & ~d_ready`.
- The slave never has more than one response pending; the master guarantees this.
- A new A transfer in the same cycle as a D transfer cannot occur.

## Test plan
- Store, then load: reset; `a_ready`=`d_ready`=1; `ir34`=0x23, `z4_input`=10, `md4_input`=20 for one decode.
  - Expect `a_channel` = {0, 2, 16'd10, 32'd20} and an AccessAck with `d_error`=0.
  - Then `ir34`=0x03 returns AccessAckData with data 20, and `load_data`=20.
- Overwrite: store 30 to address 10, then load address 10.
  - Expect data 30 on `d_channel[31:0]`.
- D back-pressure: hold `d_ready`=0 during a load.
  - Expect `d_valid`=1, `backpressureslave`=1 and `d_channel` stable for all stalled cycles.
  - On `d_ready`=1 the response completes in one cycle and `backpressureslave` drops.
- A back-pressure: hold `a_ready`=0 for 2 cycles with a store decoded.
  - Expect `a_valid`=1 and `a_channel` stable, no memory write, `d_valid`=0.
  - Releasing `a_ready` transfers the store; a later load confirms the data.
- Error: load or store to address 300 with `MEM_DEPTH`=256.
  - Expect denied=1 and `d_error`=1.
  - The store does not modify memory; the load returns data 0 and `load_data` is unchanged.
- Reset mid-request: drop `reset` while in REQ.
  - Expect all outputs 0 immediately; non-memory `ir34` (e.g. 0) issues nothing afterward.
